// File: rtl/edusoc_pkg.sv
// Shared EduSoC definitions: data-arbiter state encoding and the error read-data pattern.
package edusoc_pkg;

    typedef logic state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/edusoc_bus_watchdog.sv
// Saturating bus watchdog: counts enabled cycles since the last clear and flags
// when the count has reached TIMEOUT.
module edusoc_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_MAX);

endmodule

// File: rtl/edusoc_data_arbiter.sv
// Two-master round-robin arbiter for the EduSoC data port, with a watchdog that
// force-completes any transaction the slave never answers.
module edusoc_data_arbiter
    import edusoc_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    CPU_CLK,
    input  logic                    CPU_RES,

    input  logic                    M0_REQ,
    input  logic                    M0_WE,
    input  logic [DATA_WIDTH/8-1:0] M0_BE,
    input  logic [ADDR_WIDTH-1:0]   M0_ADDR,
    input  logic [DATA_WIDTH-1:0]   M0_WDATA,
    output logic                    M0_VALID,
    output logic [DATA_WIDTH-1:0]   M0_RDATA,

    input  logic                    M1_REQ,
    input  logic                    M1_WE,
    input  logic [DATA_WIDTH/8-1:0] M1_BE,
    input  logic [ADDR_WIDTH-1:0]   M1_ADDR,
    input  logic [DATA_WIDTH-1:0]   M1_WDATA,
    output logic                    M1_VALID,
    output logic [DATA_WIDTH-1:0]   M1_RDATA,

    output logic                    S_REQ,
    output logic                    S_WE,
    output logic [DATA_WIDTH/8-1:0] S_BE,
    output logic [ADDR_WIDTH-1:0]   S_ADDR,
    output logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic                    S_VALID,
    input  logic [DATA_WIDTH-1:0]   S_RDATA,

    output logic                    TIMEOUT_ERR,
    output logic                    GRANT
);

    localparam int BE_W = DATA_WIDTH / 8;

    state_t state;
    logic   gnt;
    logic   last_gnt;
    logic   busy;
    logic   expired;
    logic   done;
    logic   pick;
    logic [DATA_WIDTH-1:0] cpl_rdata;

    assign busy = (state == ST_BUSY);

    // On a tie the master that was not served last wins; otherwise the sole requester.
    assign pick = (M0_REQ && M1_REQ) ? ~last_gnt : M1_REQ;

    assign done = busy && (S_VALID || expired);

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RES) begin
            state    <= ST_IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (M0_REQ || M1_REQ) begin
                        gnt   <= pick;
                        state <= ST_BUSY;
                    end
                end
                default: begin
                    if (done) begin
                        last_gnt <= gnt;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Counter is held clear throughout IDLE so it always starts at zero on entry to BUSY.
    edusoc_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (CPU_CLK),
        .rst     (CPU_RES),
        .clr     (!busy),
        .en      (busy && !S_VALID),
        .expired (expired)
    );

    assign S_REQ   = busy;
    assign S_WE    = busy && (gnt ? M1_WE : M0_WE);
    assign S_BE    = busy ? (gnt ? M1_BE : M0_BE) : '0;
    assign S_ADDR  = busy ? (gnt ? M1_ADDR : M0_ADDR) : '0;
    assign S_WDATA = busy ? (gnt ? M1_WDATA : M0_WDATA) : '0;

    // Real slave data wins over a simultaneous watchdog expiry.
    assign cpl_rdata   = S_VALID ? S_RDATA : DATA_WIDTH'(ERR_RDATA);
    assign TIMEOUT_ERR = busy && !S_VALID && expired;

    assign M0_VALID = done && !gnt;
    assign M1_VALID = done && gnt;
    assign M0_RDATA = M0_VALID ? cpl_rdata : '0;
    assign M1_RDATA = M1_VALID ? cpl_rdata : '0;

    assign GRANT = busy && gnt;

    logic unused_be_w;
    assign unused_be_w = (BE_W == 0);

endmodule

// File: tb/tb_edusoc_data_arbiter.sv
// Bench for edusoc_data_arbiter: directed cycle table, a back-to-back sequence,
// then randomized traffic against a transaction-level reference model.
module tb_edusoc_data_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [BW-1:0] m0_be, m1_be;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_valid, m1_valid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_req, s_we, s_valid;
    logic [BW-1:0] s_be;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          timeout_err, grant;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    edusoc_data_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .CPU_CLK     (clk),
        .CPU_RES     (res),
        .M0_REQ      (m0_req),
        .M0_WE       (m0_we),
        .M0_BE       (m0_be),
        .M0_ADDR     (m0_addr),
        .M0_WDATA    (m0_wdata),
        .M0_VALID    (m0_valid),
        .M0_RDATA    (m0_rdata),
        .M1_REQ      (m1_req),
        .M1_WE       (m1_we),
        .M1_BE       (m1_be),
        .M1_ADDR     (m1_addr),
        .M1_WDATA    (m1_wdata),
        .M1_VALID    (m1_valid),
        .M1_RDATA    (m1_rdata),
        .S_REQ       (s_req),
        .S_WE        (s_we),
        .S_BE        (s_be),
        .S_ADDR      (s_addr),
        .S_WDATA     (s_wdata),
        .S_VALID     (s_valid),
        .S_RDATA     (s_rdata),
        .TIMEOUT_ERR (timeout_err),
        .GRANT       (grant)
    );

    typedef struct {
        logic        res, r0, w0, r1, w1, sv;
        logic [31:0] srd;
        int          own;
        logic        v0, v1;
        logic [31:0] rd;
        logic        tmo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic r0, logic w0, logic r1, logic w1,
                                logic sv, logic [31:0] srd, int own,
                                logic v0, logic v1, logic [31:0] rd, logic tmo);
        vec_t v;
        v.res = rs; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
        v.sv = sv; v.srd = srd; v.own = own;
        v.v0 = v0; v.v1 = v1; v.rd = rd; v.tmo = tmo;
        return v;
    endfunction

    // Expected output bundle for the current inputs, given which master owns the bus.
    function automatic logic [137:0] exp_out(int own, logic v0, logic v1,
                                             logic [31:0] rd, logic tmo);
        logic          sreq, swe;
        logic [3:0]    sbe;
        logic [31:0]   sa, sw;
        sreq = 1'b0; swe = 1'b0; sbe = '0; sa = '0; sw = '0;
        if (own == 0) begin
            sreq = 1'b1; swe = m0_we; sbe = m0_be; sa = m0_addr; sw = m0_wdata;
        end else if (own == 1) begin
            sreq = 1'b1; swe = m1_we; sbe = m1_be; sa = m1_addr; sw = m1_wdata;
        end
        return {sreq, swe, sbe, sa, sw, v0, (v0 ? rd : 32'h0), v1, (v1 ? rd : 32'h0),
                tmo, (own == 1)};
    endfunction

    task automatic check(string name, logic [137:0] exp);
        logic [137:0] got;
        got = {s_req, s_we, s_be, s_addr, s_wdata, m0_valid, m0_rdata,
               m1_valid, m1_rdata, timeout_err, grant};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(vec_t v);
        res      = v.res;
        m0_req   = v.r0;  m0_we = v.w0;  m0_be = 4'hF;     m0_addr = 32'h0000_0010;
        m0_wdata = 32'hAAAA_AAAA;
        m1_req   = v.r1;  m1_we = v.w1;  m1_be = 4'b0110;  m1_addr = 32'h0000_0020;
        m1_wdata = 32'h5555_5555;
        s_valid  = v.sv;  s_rdata = v.srd;
    endtask

    int          m_own, m_age, m_last;
    logic        pv0, pv1, ptmo;
    logic [31:0] prd;

    initial begin
        // single read by M0, stray S_VALID in IDLE
        tbl.push_back(mk(1,0,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,0,0,0,32'h0,           0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,0,0,1,32'h1234_5678,   0,1,0,32'h1234_5678,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'hFFFF_0000,  -1,0,0,32'h0,0));
        // reset, then both masters write continuously: grants 0,1,0,1,0,1
        tbl.push_back(mk(1,0,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        for (int k = 0; k < 6; k++) begin
            tbl.push_back(mk(0,1,1,1,1,0,32'h0,      -1,0,0,32'h0,0));
            tbl.push_back(mk(0,1,1,1,1,1,32'h0000_0100 + k, k % 2,
                             (k % 2) == 0, (k % 2) == 1, 32'h0000_0100 + k, 0));
        end
        // M1 read never answered: forced completion in the 5th BUSY cycle, late answer dropped
        tbl.push_back(mk(0,0,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,1,0,0,32'h0,          -1,0,0,32'h0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,0,0,1,0,0,32'h0,       1,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,1,0,0,32'h0,           1,0,1,32'hDEAD_BEEF,1));
        tbl.push_back(mk(0,0,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,0,0,1,32'h7777_7777,  -1,0,0,32'h0,0));
        // S_VALID in the same cycle the watchdog expires
        tbl.push_back(mk(0,1,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(0,1,0,0,0,0,32'h0,       0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,0,0,1,32'hCAFE_F00D,   0,1,0,32'hCAFE_F00D,0));
        tbl.push_back(mk(0,0,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        // reset in the 2nd BUSY cycle of an M0 transfer; next tie goes to M0
        tbl.push_back(mk(0,1,0,0,0,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,0,0,0,32'h0,           0,0,0,32'h0,0));
        tbl.push_back(mk(1,1,0,0,0,0,32'h0,           0,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,1,1,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,1,0,1,1,1,32'h0BAD_CAFE,   0,1,0,32'h0BAD_CAFE,0));
        // M1 write with BE=0110
        tbl.push_back(mk(0,0,0,1,1,0,32'h0,          -1,0,0,32'h0,0));
        tbl.push_back(mk(0,0,0,1,1,1,32'h0000_0042,   1,0,1,32'h0000_0042,0));
        tbl.push_back(mk(0,0,0,0,0,0,32'h0,          -1,0,0,32'h0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            check($sformatf("vec%0d", i), exp_out(tbl[i].own, tbl[i].v0, tbl[i].v1,
                                                  tbl[i].rd, tbl[i].tmo));
            @(posedge clk); #1;
        end

        // M0 holds REQ with an always-ready slave: one transfer every 2 cycles
        for (int i = 0; i < 6; i++) begin
            res = 1'b0; m0_req = 1'b1; m1_req = 1'b0; s_valid = 1'b1;
            s_rdata = 32'h0000_5000 + i;
            @(negedge clk);
            check($sformatf("b2b%0d", i), exp_out((i % 2) ? 0 : -1, (i % 2) == 1, 1'b0,
                                                  s_rdata, 1'b0));
            @(posedge clk); #1;
        end

        // randomized traffic against a transaction-level model
        m_own = -1; m_age = 0; m_last = 1;
        pv0 = 1'b0; pv1 = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            res = (i == 0) || ($urandom_range(0, 63) == 0);
            if (pv0 ? ($urandom_range(0, 3) == 0) : (!m0_req && $urandom_range(0, 2) == 0)) begin
                m0_req = 1'b1; m0_we = 1'($urandom); m0_be = 4'($urandom);
                m0_addr = $urandom; m0_wdata = $urandom;
            end else if (pv0) begin
                m0_req = 1'b0;
            end
            if (pv1 ? ($urandom_range(0, 3) == 0) : (!m1_req && $urandom_range(0, 2) == 0)) begin
                m1_req = 1'b1; m1_we = 1'($urandom); m1_be = 4'($urandom);
                m1_addr = $urandom; m1_wdata = $urandom;
            end else if (pv1) begin
                m1_req = 1'b0;
            end
            s_valid = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;

            pv0 = 1'b0; pv1 = 1'b0; ptmo = 1'b0; prd = 32'h0;
            if (m_own >= 0) begin
                if (s_valid) begin
                    prd = s_rdata;
                    pv0 = (m_own == 0); pv1 = (m_own == 1);
                end else if (m_age >= TMO + 1) begin
                    prd = 32'hDEAD_BEEF; ptmo = 1'b1;
                    pv0 = (m_own == 0); pv1 = (m_own == 1);
                end
            end

            @(negedge clk);
            check($sformatf("rnd%0d", i), exp_out(m_own, pv0, pv1, prd, ptmo));

            if (res) begin
                m_own = -1; m_last = 1; m_age = 0;
                pv0 = 1'b0; pv1 = 1'b0;
            end else if (m_own < 0) begin
                if (m0_req || m1_req) begin
                    m_own = (m0_req && m1_req) ? 1 - m_last : (m1_req ? 1 : 0);
                    m_age = 1;
                end
            end else if (pv0 || pv1) begin
                m_last = m_own;
                m_own  = -1;
            end else begin
                m_age++;
            end
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
